// File: rtl/ysyx_040750_muldiv_pkg.sv
// Shared constants and types for the iterative multiply/divide unit.
package ysyx_040750_muldiv_pkg;

  localparam int XLEN  = 64;
  localparam int WLEN  = 32;
  localparam int CNT_W = 6;

  localparam int OP_MUL  = 0;
  localparam int OP_MULH = 1;
  localparam int OP_DIV  = 2;
  localparam int OP_REM  = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic [XLEN-1:0] sextW(input logic [WLEN-1:0] v);
    return {{(XLEN-WLEN){v[WLEN-1]}}, v};
  endfunction

endpackage

// File: rtl/ysyx_040750_muldiv_dp.sv
// One-bit-per-cycle shift-add multiply / restoring divide on unsigned magnitudes.
module ysyx_040750_muldiv_dp
  import ysyx_040750_muldiv_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic              step_i,
  input  logic              isDiv_i,
  input  logic [XLEN-1:0]   shift_i,
  input  logic [XLEN-1:0]   operand_i,
  output logic [2*XLEN-1:0] prodNext_o,
  output logic [XLEN-1:0]   quoNext_o,
  output logic [XLEN-1:0]   remNext_o
);

  logic [XLEN-1:0] hi_q, lo_q, sh_q, opnd_q;
  logic [XLEN:0]   trial;
  logic            ge;
  logic [2*XLEN-1:0] addend;

  // Outputs are the values after the current step so the controller can
  // capture the final result on the same edge the last step completes.
  always_comb begin
    trial      = {hi_q, sh_q[XLEN-1]};
    ge         = trial >= {1'b0, opnd_q};
    addend     = sh_q[XLEN-1] ? {{XLEN{1'b0}}, opnd_q} : '0;
    prodNext_o = ({hi_q, lo_q} << 1) + addend;
    quoNext_o  = {sh_q[XLEN-2:0], ge};
    remNext_o  = ge ? (trial[XLEN-1:0] - opnd_q) : trial[XLEN-1:0];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hi_q   <= '0;
      lo_q   <= '0;
      sh_q   <= '0;
      opnd_q <= '0;
    end else if (load_i) begin
      hi_q   <= '0;
      lo_q   <= '0;
      sh_q   <= shift_i;
      opnd_q <= operand_i;
    end else if (step_i) begin
      if (isDiv_i) begin
        hi_q <= remNext_o;
        sh_q <= quoNext_o;
      end else begin
        {hi_q, lo_q} <= prodNext_o;
        sh_q         <= sh_q << 1;
      end
    end
  end

endmodule

// File: rtl/ysyx_040750_muldiv_ctrl.sv
// Multicycle MUL/DIV controller: FSM, special-case detect, sign fix-up and
// pipeline handshake around the shared datapath.
module ysyx_040750_muldiv_ctrl
  import ysyx_040750_muldiv_pkg::*;
(
  input  logic            I_sys_clk,
  input  logic            I_rst,
  input  logic            I_start,
  input  logic [3:0]      I_op,
  input  logic            I_signed,
  input  logic            I_word,
  input  logic [XLEN-1:0] I_src1,
  input  logic [XLEN-1:0] I_src2,
  input  logic            I_allowout,
  input  logic            I_flush,
  output logic            O_alu_output_valid,
  output logic [XLEN-1:0] O_result,
  output logic            O_busy
);

  state_e            state_q;
  logic [CNT_W-1:0]  count_q;
  logic [3:0]        op_q;
  logic              word_q, negQ_q, negR_q;
  logic [XLEN-1:0]   result_q;

  logic              isDivIn, signA, signB, divZero, overflow, special, accept;
  logic [WLEN-1:0]   magA32, magB32;
  logic [XLEN-1:0]   magA64, magB64, fullA, fullB, posA, posB, dividendW, specialRes;
  logic [2*XLEN-1:0] prodNext, prodS;
  logic [XLEN-1:0]   quoNext, remNext, quoS, remS, result_d;

  // Operands are reduced to magnitudes; W forms are pre-shifted to the top so
  // the datapath always consumes bits from bit 63 downwards.
  always_comb begin
    isDivIn   = I_op[OP_DIV] | I_op[OP_REM];
    signA     = I_signed & (I_word ? I_src1[WLEN-1] : I_src1[XLEN-1]);
    signB     = I_signed & (I_word ? I_src2[WLEN-1] : I_src2[XLEN-1]);
    magA32    = signA ? (~I_src1[WLEN-1:0] + 32'd1) : I_src1[WLEN-1:0];
    magB32    = signB ? (~I_src2[WLEN-1:0] + 32'd1) : I_src2[WLEN-1:0];
    magA64    = signA ? (~I_src1 + 64'd1) : I_src1;
    magB64    = signB ? (~I_src2 + 64'd1) : I_src2;
    fullA     = I_word ? {{(XLEN-WLEN){1'b0}}, magA32} : magA64;
    fullB     = I_word ? {{(XLEN-WLEN){1'b0}}, magB32} : magB64;
    posA      = I_word ? {magA32, {(XLEN-WLEN){1'b0}}} : magA64;
    posB      = I_word ? {magB32, {(XLEN-WLEN){1'b0}}} : magB64;
    divZero   = I_word ? (I_src2[WLEN-1:0] == '0) : (I_src2 == '0);
    overflow  = I_signed & (I_word ?
                ((I_src1[WLEN-1:0] == 32'h8000_0000) && (I_src2[WLEN-1:0] == '1)) :
                ((I_src1 == {1'b1, {(XLEN-1){1'b0}}}) && (I_src2 == '1)));
    special   = isDivIn & (divZero | overflow);
    dividendW = I_word ? sextW(I_src1[WLEN-1:0]) : I_src1;
    if (divZero) specialRes = I_op[OP_DIV] ? '1 : dividendW;
    else         specialRes = I_op[OP_DIV] ? dividendW : '0;
    accept    = I_start & ~I_flush &
                ((state_q == IDLE) | ((state_q == DONE) & I_allowout));
  end

  always_comb begin
    prodS    = negQ_q ? (~prodNext + 128'd1) : prodNext;
    quoS     = negQ_q ? (~quoNext + 64'd1) : quoNext;
    remS     = negR_q ? (~remNext + 64'd1) : remNext;
    result_d = '0;
    unique case (1'b1)
      op_q[OP_REM]:  result_d = word_q ? sextW(remS[WLEN-1:0]) : remS;
      op_q[OP_DIV]:  result_d = word_q ? sextW(quoS[WLEN-1:0]) : quoS;
      op_q[OP_MULH]: result_d = word_q ? sextW(prodS[2*WLEN-1:WLEN]) : prodS[2*XLEN-1:XLEN];
      op_q[OP_MUL]:  result_d = word_q ? sextW(prodS[WLEN-1:0]) : prodS[XLEN-1:0];
      default:       result_d = '0;
    endcase
  end

  ysyx_040750_muldiv_dp u_dp (
    .clk_i      (I_sys_clk),
    .rst_i      (I_rst),
    .load_i     (accept & ~special),
    .step_i     ((state_q == CALC) & ~I_flush),
    .isDiv_i    (op_q[OP_DIV] | op_q[OP_REM]),
    .shift_i    (isDivIn ? posA : posB),
    .operand_i  (isDivIn ? fullB : fullA),
    .prodNext_o (prodNext),
    .quoNext_o  (quoNext),
    .remNext_o  (remNext)
  );

  // Flush dominates everything and keeps the last result visible.
  always_ff @(posedge I_sys_clk or posedge I_rst) begin
    if (I_rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      op_q     <= '0;
      word_q   <= 1'b0;
      negQ_q   <= 1'b0;
      negR_q   <= 1'b0;
      result_q <= '0;
    end else if (I_flush) begin
      state_q <= IDLE;
      count_q <= '0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (accept) begin
            op_q   <= I_op;
            word_q <= I_word;
            negQ_q <= signA ^ signB;
            negR_q <= signA;
            if (special) begin
              state_q  <= DONE;
              count_q  <= '0;
              result_q <= specialRes;
            end else begin
              state_q <= CALC;
              count_q <= I_word ? CNT_W'(WLEN-1) : CNT_W'(XLEN-1);
            end
          end else if ((state_q == DONE) && I_allowout) begin
            state_q <= IDLE;
          end
        end
        CALC: begin
          if (count_q == '0) begin
            state_q  <= DONE;
            result_q <= result_d;
          end else begin
            count_q <= count_q - CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign O_alu_output_valid = ((state_q == IDLE) & ~I_start) | (state_q == DONE);
  assign O_busy             = (state_q != IDLE);
  assign O_result           = result_q;

endmodule
